pam4_slicer_rx: RTL and testbench

- Receive-side counterpart of the 3-bit 4-PAM symbol encoding that drives the FIR input.
- Consumes the 16-bit FIR output at the 600 kHz sample strobe and decimates by the 3x oversampling factor.
- Slices each kept sample into one of the four 4-PAM codes and buffers the decoded symbols in a small FIFO.
- Sits after the FIR top level; used as an on-chip loopback checker and as the demodulator front end.

---
 rtl/fir_pkg.sv | 27 ++
 rtl/sym_fifo.sv | 67 ++++++
 rtl/pam4_slicer_rx.sv | 170 +++++++++++++++++
 tb/tb_pam4_slicer_rx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared 4-PAM code constants, slicer FSM states and helpers
package fir_pkg;

   localparam logic [2:0] PAM_P1 = 3'b001;
   localparam logic [2:0] PAM_P3 = 3'b011;
   localparam logic [2:0] PAM_M1 = 3'b111;
   localparam logic [2:0] PAM_M3 = 3'b101;

   // Centre tap 500 with a +/-2 symbol swing
   localparam int NOM_THRESH = 1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      RUN  = 2'd2
   } slicer_state_t;

   function automatic logic [1:0] pam_idx(input logic [2:0] c);
      case (c)
         PAM_P3:  return 2'd0;
         PAM_P1:  return 2'd1;
         PAM_M1:  return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/sym_fifo.sv
// rtl/sym_fifo.sv - synchronous first-word-fall-through FIFO with flush
module sym_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_last;
   logic             w_pop;
   logic             w_wr;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   assign w_pop   = i_pop & ~o_empty;
   // A pop in the same cycle frees the slot, so a push while full still lands
   assign w_wr    = i_push & (~o_full | w_pop);

   // Head falls through; when empty the last head seen is held
   assign o_data  = o_empty ? r_last : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= '0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_wr && !w_pop)
            r_count <= r_count + (AW + 1)'(1);
         else if (w_pop && !w_wr)
            r_count <= r_count - (AW + 1)'(1);
         if (!o_empty)
            r_last <= r_mem[r_rd_ptr];
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr && !i_clr)
         r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/pam4_slicer_rx.sv
// rtl/pam4_slicer_rx.sv - 4-PAM decimating slicer with lock FSM and symbol FIFO (option SLICER_STATS_EN)
module pam4_slicer_rx
   import fir_pkg::*;
#(
   parameter int OSR         = 3,
   parameter int WARMUP_SYMS = 11,
   parameter int FIFO_DEPTH  = 8,
   parameter int TH_W        = 16
) (
   input  logic            iClk12M,
   input  logic            iRsn,
   input  logic            iEnSample600k,
   input  logic            iCoeffUpdateFlag,
   input  logic [15:0]     iFirOut,
   input  logic [1:0]      iPhaseSel,
   input  logic [TH_W-1:0] iThresh,
   input  logic            iRdEn,
   output logic [2:0]      oSymCode,
   output logic            oEmpty,
   output logic            oFull,
   output logic            oOverflow,
`ifdef SLICER_STATS_EN
   output logic            oLocked,
   output logic [15:0]     oCntP3,
   output logic [15:0]     oCntP1,
   output logic [15:0]     oCntM1,
   output logic [15:0]     oCntM3
`else
   output logic            oLocked
`endif
);

   localparam int               CMP_W   = TH_W + 1;
   localparam int               WU_W    = $clog2(WARMUP_SYMS + 1);
   localparam logic [1:0]       PH_LAST = 2'(OSR - 1);
   localparam logic [WU_W-1:0]  WU_LAST = WU_W'(WARMUP_SYMS - 1);

   slicer_state_t          r_state;
   slicer_state_t          w_state_nxt;
   logic [1:0]             r_phase;
   logic [WU_W-1:0]        r_warm;
   logic                   r_ovf;
   logic                   w_clr;
   logic                   w_sym_end;
   logic                   w_dec;
   logic                   w_empty;
   logic                   w_full;
   logic                   w_pop_ok;
   logic signed [CMP_W-1:0] w_v;
   logic signed [CMP_W-1:0] w_t;
   logic signed [CMP_W-1:0] w_nt;
   logic [2:0]             w_code;

   // IDLE and the cycle the flag is seen both act as a synchronous flush
   assign w_clr     = iCoeffUpdateFlag | (r_state == IDLE);
   assign w_sym_end = iEnSample600k & (r_phase == PH_LAST);

   always_ff @(posedge iClk12M or negedge iRsn) begin
      if (!iRsn)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (iCoeffUpdateFlag)
         w_state_nxt = IDLE;
      else begin
         case (r_state)
            IDLE:    w_state_nxt = ACQ;
            ACQ:     if (w_sym_end && r_warm == WU_LAST) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      oLocked = 1'b0;
      if (r_state == RUN)
         oLocked = 1'b1;
   end

   always_ff @(posedge iClk12M or negedge iRsn) begin
      if (!iRsn) begin
         r_phase <= '0;
         r_warm  <= '0;
      end else if (w_clr) begin
         r_phase <= '0;
         r_warm  <= '0;
      end else begin
         if (iEnSample600k)
            r_phase <= (r_phase == PH_LAST) ? 2'd0 : r_phase + 2'd1;
         if (r_state == ACQ && w_sym_end)
            r_warm <= r_warm + WU_W'(1);
      end
   end

   assign w_dec = (r_state == RUN) & ~iCoeffUpdateFlag & iEnSample600k & (r_phase == iPhaseSel);

   // One extra bit so that -T stays representable
   assign w_v  = {{(CMP_W - 16){iFirOut[15]}}, iFirOut};
   assign w_t  = {1'b0, iThresh};
   assign w_nt = -w_t;

   always_comb begin
      w_code = PAM_M3;
      if (w_v >= w_t)
         w_code = PAM_P3;
      else if (!w_v[CMP_W-1])
         w_code = PAM_P1;
      else if (w_v >= w_nt)
         w_code = PAM_M1;
   end

   assign w_pop_ok = iRdEn & ~w_empty;

   always_ff @(posedge iClk12M or negedge iRsn) begin
      if (!iRsn)
         r_ovf <= 1'b0;
      else if (w_clr)
         r_ovf <= 1'b0;
      else if (w_dec && w_full && !w_pop_ok)
         r_ovf <= 1'b1;
   end

   sym_fifo #(
      .WIDTH (3),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (iClk12M),
      .i_rst_n (iRsn),
      .i_clr   (w_clr),
      .i_push  (w_dec),
      .i_data  (w_code),
      .i_pop   (iRdEn),
      .o_data  (oSymCode),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign oEmpty    = w_empty;
   assign oFull     = w_full;
   assign oOverflow = r_ovf;

`ifdef SLICER_STATS_EN
   logic [15:0] r_cnt [4];
   logic [1:0]  w_idx;

   assign w_idx = pam_idx(w_code);

   // Dropped decisions are still counted; counters stick at all-ones
   always_ff @(posedge iClk12M or negedge iRsn) begin
      if (!iRsn) begin
         for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
      end else if (w_clr) begin
         for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
      end else if (w_dec && r_cnt[w_idx] != 16'hFFFF) begin
         r_cnt[w_idx] <= r_cnt[w_idx] + 16'd1;
      end
   end

   assign oCntP3 = r_cnt[0];
   assign oCntP1 = r_cnt[1];
   assign oCntM1 = r_cnt[2];
   assign oCntM3 = r_cnt[3];
`endif

endmodule

// File: tb/tb_pam4_slicer_rx.sv
// tb/tb_pam4_slicer_rx.sv - randomized self-checking bench for pam4_slicer_rx (option SLICER_STATS_EN)
module tb_pam4_slicer_rx;
   import fir_pkg::*;

   localparam int LOCK_STROBES = 33;
   localparam int DEPTH        = 8;

   logic        clk = 1'b0;
   logic        rsn;
   logic        stb;
   logic        flag;
   logic [15:0] fir;
   logic [1:0]  sel;
   logic [15:0] th;
   logic        rd;
   logic [2:0]  sym;
   logic        empty;
   logic        full;
   logic        ovf;
   logic        locked;
`ifdef SLICER_STATS_EN
   logic [15:0] cp3, cp1, cm1, cm3;
`endif

   int total = 0;
   int bad   = 0;

   bit m_idle;
   int m_sidx;
   int m_q[$];
   bit m_ovf;
   int m_last;
   int m_dec;

   always #5 clk = ~clk;

   pam4_slicer_rx dut (
      .iClk12M          (clk),
      .iRsn             (rsn),
      .iEnSample600k    (stb),
      .iCoeffUpdateFlag (flag),
      .iFirOut          (fir),
      .iPhaseSel        (sel),
      .iThresh          (th),
      .iRdEn            (rd),
      .oSymCode         (sym),
      .oEmpty           (empty),
      .oFull            (full),
      .oOverflow        (ovf),
`ifdef SLICER_STATS_EN
      .oLocked          (locked),
      .oCntP3           (cp3),
      .oCntP1           (cp1),
      .oCntM1           (cm1),
      .oCntM3           (cm3)
`else
      .oLocked          (locked)
`endif
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int ref_code(input int v, input int t);
      if (v >= t)       return 3;
      else if (v >= 0)  return 1;
      else if (v >= -t) return 7;
      else              return 5;
   endfunction

   function automatic logic [15:0] pick_fir(input int t);
      int k = $urandom_range(0, 7);
      int v;
      case (k)
         0: v = t;
         1: v = -t;
         2: v = t - 1;
         3: v = -t - 1;
         4: v = 0;
         5: v = -1;
         6: v = t + 1;
         default: v = int'($urandom_range(0, 65535));
      endcase
      return 16'(v);
   endfunction

   task automatic model_reset();
      m_idle = 1; m_sidx = 0; m_q.delete(); m_ovf = 0; m_last = 0; m_dec = 0;
   endtask

   // Strobe index since leaving IDLE decides everything: lock after 33 strobes, phase = index mod 3
   task automatic model_clk();
      if (flag) model_reset();
      else if (m_idle) m_idle = 0;
      else begin
         int  sz;
         bit  can_pop;
         sz = m_q.size();
         can_pop = rd && sz > 0;
         if (can_pop) m_last = m_q.pop_front();
         if (stb) begin
            if (m_sidx >= LOCK_STROBES && (m_sidx % 3) == int'(sel)) begin
               m_dec++;
               if (sz < DEPTH || can_pop) m_q.push_back(ref_code(int'($signed(fir)), int'(th)));
               else m_ovf = 1;
            end
            m_sidx++;
         end
      end
   endtask

   task automatic check_outs();
      chk("empty",  empty,  int'(m_q.size() == 0));
      chk("full",   full,   int'(m_q.size() == DEPTH));
      chk("head",   sym,    (m_q.size() > 0) ? m_q[0] : m_last);
      chk("ovf",    ovf,    int'(m_ovf));
      chk("locked", locked, int'(!m_idle && m_sidx >= LOCK_STROBES));
   endtask

   task automatic step(input bit s, input logic [15:0] f, input bit r);
      stb = s; fir = f; rd = r;
      @(posedge clk);
      model_clk();
      @(negedge clk);
      check_outs();
      stb = 0; rd = 0;
   endtask

   task automatic strobe_sym(input logic [15:0] f);
      step(1, f, 0);
      step(0, 16'h0, 0);
   endtask

   task automatic acquire();
      flag = 1;
      step(0, 16'h0, 0);
      step(0, 16'h0, 0);
      flag = 0;
      step(0, 16'h0, 0);
      for (int i = 0; i < LOCK_STROBES - 1; i++) strobe_sym(pick_fir(int'(th)));
      chk("prelock", locked, 0);
      chk("prelock_empty", empty, 1);
      strobe_sym(pick_fir(int'(th)));
      chk("lock33", locked, 1);
   endtask

   int dvals[7] = '{1500, 500, -500, -1500, 1000, 0, -1000};
   int dexp[7]  = '{3, 1, 7, 5, 3, 1, 7};
   int ovals[10] = '{2000, 300, -300, -2000, 2000, 300, -300, -2000, 0, 1000};
   int oexp[8]  = '{3, 1, 7, 5, 3, 1, 7, 5};
   int ppexp[8] = '{1, 7, 5, 3, 1, 7, 5, 3};

   initial begin
      rsn = 0; flag = 0; stb = 0; fir = '0; sel = 0; th = 16'(NOM_THRESH); rd = 0;
      model_reset();
      @(negedge clk);
      chk("rst_sym", sym, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_locked", locked, 0);
      @(negedge clk);
      rsn = 1;

      // Directed slicing on phase 0 with 700 on the other phases
      acquire();
      for (int i = 0; i < 7; i++) begin
         strobe_sym(16'(dvals[i]));
         strobe_sym(16'(700));
         strobe_sym(16'(700));
      end
      for (int i = 0; i < 7; i++) begin
         chk("dir_code", sym, dexp[i]);
         step(0, 16'h0, 1);
      end
      chk("dir_drained", empty, 1);
      chk("dir_hold", sym, 7);

      // Overflow: ten decisions into eight entries
      for (int i = 0; i < 10; i++) begin
         strobe_sym(16'(ovals[i]));
         strobe_sym(16'(700));
         strobe_sym(16'(700));
         if (i == 7) begin
            chk("full8", full, 1);
            chk("ovf8", ovf, 0);
         end
         if (i == 8) chk("ovf9", ovf, 1);
      end
      for (int i = 0; i < 8; i++) begin
         chk("ovf_order", sym, oexp[i]);
         step(0, 16'h0, 1);
      end
      chk("ovf_sticky", ovf, 1);

      // Push and pop together while full
      acquire();
      chk("reacq_ovf", ovf, 0);
      for (int i = 0; i < 8; i++) begin
         strobe_sym(16'(ovals[i]));
         strobe_sym(16'(700));
         strobe_sym(16'(700));
      end
      step(1, 16'(2000), 1);
      chk("pp_full", full, 1);
      chk("pp_ovf", ovf, 0);
      step(0, 16'h0, 0);
      strobe_sym(16'(700));
      strobe_sym(16'(700));
      for (int i = 0; i < 8; i++) begin
         chk("pp_order", sym, ppexp[i]);
         step(0, 16'h0, 1);
      end

      // Random thresholds, phases, strobes and pops, with mid-run coefficient updates
      for (int round = 0; round < 4; round++) begin
         case (round)
            0: th = 16'(NOM_THRESH);
            1: th = 16'h0000;
            2: th = 16'hFFFF;
            default: th = 16'($urandom_range(1, 40000));
         endcase
         sel = 2'($urandom_range(0, 3));
         acquire();
         for (int n = 0; n < 600; n++) begin
            if (n == 300 && (round % 2) == 1) begin
               flag = 1;
               step(1, pick_fir(int'(th)), 1);
               flag = 0;
            end
            step(bit'($urandom_range(0, 1)), pick_fir(int'(th)), ($urandom_range(0, 2) == 0));
         end
`ifdef SLICER_STATS_EN
         chk("stats_sum", int'(cp3) + int'(cp1) + int'(cm1) + int'(cm3), m_dec);
`endif
      end

      // Asynchronous reset in the middle of RUN
      sel = 0; th = 16'(NOM_THRESH);
      acquire();
      for (int i = 0; i < 3; i++) begin
         strobe_sym(16'(1500));
         strobe_sym(16'(700));
         strobe_sym(16'(700));
      end
      chk("pre_rst_empty", empty, 0);
      #2 rsn = 0;
      #1;
      chk("mid_rst_sym", sym, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_ovf", ovf, 0);
      chk("mid_rst_locked", locked, 0);
      model_reset();
      @(negedge clk);
      rsn = 1;
      step(0, 16'h0, 0);
      step(1, 16'(1500), 0);
      acquire();
      strobe_sym(16'(-1500));
      chk("post_rst_code", sym, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
